pattern_word_generator: RTL and testbench
=========================================

PATTERN_WORD_GENERATOR -- requirements
Module: pattern_word_generator

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all ports SHALL be as follows.
REQ-002 Clk  input  1  rising-edge clock; sole clock.
REQ-003 Rst  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  request to build one word; sampled only in IDLE.
REQ-005 Pattern  input  3  target pattern; Pattern[k] is the bit expected at word position i+k.
REQ-006 Copies  input  4  number of back-to-back pattern copies placed from bit 0 upward.
REQ-007 Fill  input  1  value of every word bit not covered by a pattern copy.
REQ-008 WordOut  output  32  generated word.
REQ-009 CountOut  output  32  number of matching windows in WordOut, using the 3-bit window count definition in REQ-017.
REQ-010 Busy  output  1  high in BUILD and COUNT.
REQ-011 Done  output  1  one-cycle pulse; WordOut and CountOut are valid from this cycle until the next accepted Start.

Function
REQ-012 The FSM SHALL have states IDLE, BUILD, COUNT and DONE, and SHALL make exactly one transition per Clk edge when not in reset.
REQ-013 In IDLE with Start=1, the block SHALL latch Pattern, Copies and Fill, clear the bit index and CountOut, and enter BUILD; inputs SHALL be ignored at all other times.
REQ-014 Effective copies SHALL be E = min(Copies, 10); Copies 11..15 SHALL behave as 10.
REQ-015 BUILD SHALL write one bit per cycle for index i=0..31 (32 cycles): bit i = Pattern[i mod 3] if i < 3*E, else Fill; it SHALL then enter COUNT.
REQ-016 While in BUILD, WordOut SHALL hold its previous value for positions not yet written in this operation.
REQ-017 COUNT SHALL evaluate one window per cycle for i=0..29 (30 cycles), incrementing CountOut when WordOut[i]==Pattern[0], WordOut[i+1]==Pattern[1] and WordOut[i+2]==Pattern[2]; it SHALL then enter DONE.
REQ-018 Windows SHALL NOT wrap; index 30 and index 31 are never window starts.
REQ-019 DONE SHALL last one cycle with Done=1 and then return to IDLE.
REQ-020 Latency: if Start is sampled at edge 0, Done SHALL be high after edge 63; a new Start SHALL be accepted at the earliest on edge 64.
REQ-021 Start held high continuously SHALL produce back-to-back operations, each relatching its inputs in IDLE.
REQ-022 CountOut SHALL be zero-extended to 32 bits; its maximum value is 30 and it SHALL never overflow.
REQ-023 Input changes during BUILD or COUNT SHALL have no effect on the current result.

Reset
REQ-024 When Rst=1 at a Clk edge, the FSM SHALL enter IDLE and WordOut, CountOut, Busy and Done SHALL all be 0; Rst SHALL take priority over Start.
REQ-025 Rst asserted mid-operation SHALL abort the operation with no Done pulse; the next Start SHALL begin a fresh operation.

Structure
REQ-026 The package pattern_pkg SHALL hold WORD_W=32, PAT_W=3, MAX_COPIES=10, N_WINDOWS=30, and the FSM state typedef.
REQ-027 The 3-bit window compare SHALL be a combinational sub-module, pattern_window_cmp, so that it is reusable by the detector side.
REQ-028 The bit index and window index SHALL share one 5-bit counter.

Verification
REQ-029 Pattern=3'b101, Copies=1, Fill=0 -> WordOut=32'h00000005, CountOut=1, Done pulse after edge 63.
REQ-030 Pattern=3'b001, Copies=10, Fill=1 -> WordOut=32'hC9249249, CountOut=10; repeating with Copies=15 SHALL give an identical result.
REQ-031 Pattern=3'b000, Copies=0, Fill=0 -> WordOut=32'h00000000, CountOut=30 (no-wrap boundary case).
REQ-032 Pattern=3'b111, Copies=2, Fill=1 -> WordOut=32'hFFFFFFFF, CountOut=30; Pattern changed to 3'b000 during BUILD -> result unchanged.
REQ-033 Rst pulsed at edge 40 of an operation -> IDLE, all outputs 0, no Done pulse; the next Start SHALL complete normally with correct values.
REQ-034 Start held high for 200 cycles -> Done pulses every 64 cycles; Busy low only in IDLE and DONE.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared constants, FSM state type and small helpers for the pattern word generator.
package pattern_pkg;

    localparam int WORD_W     = 32;  // generated word width
    localparam int PAT_W      = 3;   // pattern / window width
    localparam int MAX_COPIES = 10;  // 10 copies * 3 bits = 30 bits, the most that fit in a word
    localparam int N_WINDOWS  = 30;  // window starts 0..29; no wrap past bit 31
    localparam int IDX_W      = 5;   // shared bit/window index width
    localparam int COPIES_W   = 4;   // width of the Copies request

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUILD = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Number of word bits covered by pattern copies: 3 * min(copies, 10).
    // Computed once at Start so BUILD only needs a single compare per bit.
    function automatic logic [IDX_W-1:0] cover_limit(input logic [COPIES_W-1:0] copies);
        logic [COPIES_W-1:0] eff;
        eff = (copies > COPIES_W'(MAX_COPIES)) ? COPIES_W'(MAX_COPIES) : copies;
        return IDX_W'(eff) * IDX_W'(PAT_W);
    endfunction

    // Position inside the pattern for a given word bit index.
    function automatic logic [1:0] pat_phase(input logic [IDX_W-1:0] idx);
        return 2'(idx % IDX_W'(PAT_W));
    endfunction

endpackage

// File: rtl/pattern_window_cmp.sv
// Combinational compare of one window of word bits against the target pattern.
// Kept as its own block so a detector can reuse it unchanged.
module pattern_window_cmp
    import pattern_pkg::*;
#(
    parameter int W = PAT_W
) (
    input  logic [W-1:0] window_i,
    input  logic [W-1:0] pattern_i,
    output logic         match_o
);

    // Every bit of the window must equal the pattern bit at the same offset.
    logic [W-1:0] bit_eq;

    for (genvar gi = 0; gi < W; gi++) begin : g_bit_eq
        assign bit_eq[gi] = (window_i[gi] == pattern_i[gi]);
    end

    assign match_o = &bit_eq;

endmodule

// File: rtl/pattern_word_generator.sv
// Builds a 32-bit word from repeated copies of a 3-bit pattern (one bit per
// cycle), then counts the non-wrapping 3-bit windows equal to that pattern
// (one window per cycle). One 5-bit index serves both passes.
module pattern_word_generator
    import pattern_pkg::*;
(
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Start,
    input  logic [PAT_W-1:0]    Pattern,
    input  logic [COPIES_W-1:0] Copies,
    input  logic                Fill,
    output logic [WORD_W-1:0]   WordOut,
    output logic [WORD_W-1:0]   CountOut,
    output logic                Busy,
    output logic                Done
);

    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(WORD_W - 1);
    localparam logic [IDX_W-1:0] LAST_WIN = IDX_W'(N_WINDOWS - 1);

    state_t              state_q,  state_d;
    logic [IDX_W-1:0]    idx_q,    idx_d;     // bit index in BUILD, window start in COUNT
    logic [PAT_W-1:0]    pat_q,    pat_d;     // pattern latched at Start
    logic [IDX_W-1:0]    limit_q,  limit_d;   // bits below this index come from the pattern
    logic                fill_q,   fill_d;
    logic [WORD_W-1:0]   word_q,   word_d;
    logic [IDX_W-1:0]    count_q,  count_d;   // max 30, so 5 bits never overflow

    logic                build_bit;
    logic [PAT_W-1:0]    window;
    logic                win_match;

    // Bit written at the current index: pattern bit inside the covered span, Fill above it.
    assign build_bit = (idx_q < limit_q) ? pat_q[pat_phase(idx_q)] : fill_q;

    // Window starting at the current index. COUNT only visits 0..29, so idx+2 stays in range.
    for (genvar gi = 0; gi < PAT_W; gi++) begin : g_window
        assign window[gi] = word_q[idx_q + IDX_W'(gi)];
    end

    pattern_window_cmp #(
        .W (PAT_W)
    ) u_window_cmp (
        .window_i  (window),
        .pattern_i (pat_q),
        .match_o   (win_match)
    );

    // Next-state logic: one state step per clock; inputs are only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pat_d   = pat_q;
        limit_d = limit_q;
        fill_d  = fill_q;
        word_d  = word_q;
        count_d = count_q;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    pat_d   = Pattern;
                    limit_d = cover_limit(Copies);
                    fill_d  = Fill;
                    idx_d   = '0;
                    count_d = '0;
                    state_d = ST_BUILD;
                end
            end

            ST_BUILD: begin
                // Only the indexed bit changes; bits not yet reached keep the old word.
                word_d[idx_q] = build_bit;
                if (idx_q == LAST_BIT) begin
                    idx_d   = '0;
                    state_d = ST_COUNT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            ST_COUNT: begin
                if (win_match) begin
                    count_d = count_q + 1'b1;
                end
                if (idx_q == LAST_WIN) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset clears everything and wins over Start.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            pat_q   <= '0;
            limit_q <= '0;
            fill_q  <= 1'b0;
            word_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pat_q   <= pat_d;
            limit_q <= limit_d;
            fill_q  <= fill_d;
            word_q  <= word_d;
            count_q <= count_d;
        end
    end

    assign WordOut  = word_q;
    assign CountOut = {{(WORD_W - IDX_W){1'b0}}, count_q};
    assign Busy     = (state_q == ST_BUILD) || (state_q == ST_COUNT);
    assign Done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_pattern_word_generator.sv
// Directed bench for pattern_word_generator. Stimulus is driven and outputs are
// sampled on the falling edge; "edge e" means the e-th rising edge after the
// edge that accepted Start (edge 0), so a value sampled just before edge e is
// the value held in the cycle that edge e closes.
module tb_pattern_word_generator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  pattern;
    logic [3:0]  copies;
    logic        fill;
    logic [31:0] word_out;
    logic [31:0] count_out;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pattern_word_generator dut (
        .Clk      (clk),
        .Rst      (rst),
        .Start    (start),
        .Pattern  (pattern),
        .Copies   (copies),
        .Fill     (fill),
        .WordOut  (word_out),
        .CountOut (count_out),
        .Busy     (busy),
        .Done     (done)
    );

    // Reset values and reset priority over Start.
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; pattern = 3'b000; copies = 4'd0; fill = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (word_out !== 32'h0) begin n_err++; $display("FAIL reset_word: got %h want %h", word_out, 32'h0); end
        n_vec++; if (count_out !== 32'h0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count_out); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        start = 1'b1; pattern = 3'b101; copies = 4'd1;
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_priority_busy: got %b want 0", busy); end
        start = 1'b0; rst = 1'b0;
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_after_reset_busy: got %b want 0", busy); end
        $display("reset: outputs cleared, Rst over Start checked");
    endtask

    // One full operation with timing checks; optional input changes during BUILD.
    task automatic run_op(input string name, input logic [2:0] pat, input logic [3:0] cp,
                          input logic fl, input bit perturb,
                          input logic [31:0] exp_word, input logic [31:0] exp_count);
        int first_done = -1;
        int done_cycles = 0;
        int bad_busy = 0;
        @(negedge clk);
        pattern = pat; copies = cp; fill = fl; start = 1'b1;
        @(negedge clk);                      // edge 0 accepted Start
        start = 1'b0;
        for (int e = 1; e <= 63; e++) begin
            if (done === 1'b1) begin
                done_cycles++;
                if (first_done < 0) first_done = e;
            end
            if (busy !== (e <= 62)) bad_busy++;
            if (perturb && e == 5) begin
                pattern = ~pat; copies = 4'd0; fill = ~fl;
            end
            if (e == 63) begin
                n_vec++; if (word_out !== exp_word) begin n_err++; $display("FAIL %s word: got %h want %h", name, word_out, exp_word); end
                n_vec++; if (count_out !== exp_count) begin n_err++; $display("FAIL %s count: got %0d want %0d", name, count_out, exp_count); end
            end
            if (e < 63) @(negedge clk);
        end
        n_vec++; if (first_done !== 63) begin n_err++; $display("FAIL %s done_edge: got %0d want 63", name, first_done); end
        n_vec++; if (done_cycles !== 1) begin n_err++; $display("FAIL %s done_width: got %0d want 1", name, done_cycles); end
        n_vec++; if (bad_busy !== 0) begin n_err++; $display("FAIL %s busy_profile: got %0d bad cycles want 0", name, bad_busy); end
        @(negedge clk);                      // cycle closed by edge 64: back in IDLE
        n_vec++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL %s idle_flags: got busy=%b done=%b want 0 0", name, busy, done); end
        n_vec++; if (word_out !== exp_word) begin n_err++; $display("FAIL %s word_held: got %h want %h", name, word_out, exp_word); end
        $display("%s: pat=%b copies=%0d fill=%b -> word=%h count=%0d done@%0d", name, pat, cp, fl, word_out, count_out, first_done);
    endtask

    task automatic test_single_copy();
        run_op("single_copy", 3'b101, 4'd1, 1'b0, 1'b0, 32'h0000_0005, 32'd1);
    endtask

    task automatic test_full_copies();
        run_op("copies_10", 3'b001, 4'd10, 1'b1, 1'b0, 32'hC924_9249, 32'd10);
        run_op("copies_15", 3'b001, 4'd15, 1'b1, 1'b0, 32'hC924_9249, 32'd10);
    endtask

    task automatic test_no_wrap();
        run_op("all_zero", 3'b000, 4'd0, 1'b0, 1'b0, 32'h0000_0000, 32'd30);
    endtask

    task automatic test_input_freeze();
        run_op("freeze", 3'b111, 4'd2, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd30);
    endtask

    task automatic test_fill_only();
        run_op("fill_only", 3'b010, 4'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd0);
    endtask

    // Unwritten positions keep the previous word while BUILD is in progress.
    task automatic test_build_hold();
        int waited = 0;
        @(negedge clk);
        pattern = 3'b000; copies = 4'd10; fill = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);          // edges 1..10 wrote bits 0..9
        n_vec++; if (word_out !== 32'hFFFF_FC00) begin n_err++; $display("FAIL build_hold word: got %h want %h", word_out, 32'hFFFF_FC00); end
        n_vec++; if (count_out !== 32'd0) begin n_err++; $display("FAIL build_hold count: got %0d want 0", count_out); end
        while (done !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL build_hold timeout: got done=%b want 1", done); end
        n_vec++; if (word_out !== 32'h0) begin n_err++; $display("FAIL build_hold final_word: got %h want %h", word_out, 32'h0); end
        n_vec++; if (count_out !== 32'd30) begin n_err++; $display("FAIL build_hold final_count: got %0d want 30", count_out); end
        @(negedge clk);
        $display("build_hold: partial word FFFFFC00 expected after 10 bits, final %h/%0d", word_out, count_out);
    endtask

    // Reset at edge 40 aborts with no Done; a following operation is normal.
    task automatic test_mid_reset();
        int seen = 0;
        @(negedge clk);
        pattern = 3'b111; copies = 4'd10; fill = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(negedge clk);          // just before edge 40
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++; if (word_out !== 32'h0) begin n_err++; $display("FAIL mid_reset word: got %h want %h", word_out, 32'h0); end
        n_vec++; if (count_out !== 32'h0) begin n_err++; $display("FAIL mid_reset count: got %0d want 0", count_out); end
        n_vec++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL mid_reset flags: got busy=%b done=%b want 0 0", busy, done); end
        repeat (70) begin
            if (done === 1'b1) seen++;
            @(negedge clk);
        end
        n_vec++; if (seen !== 0) begin n_err++; $display("FAIL mid_reset stray_done: got %0d pulses want 0", seen); end
        $display("mid_reset: aborted at edge 40, stray done pulses=%0d", seen);
        run_op("after_reset", 3'b110, 4'd3, 1'b0, 1'b0, 32'h0000_01B6, 32'd3);
    endtask

    // Start held high: operations every 64 cycles, each relatching inputs.
    task automatic test_back_to_back();
        int bad_done = 0;
        int bad_busy = 0;
        int n_done = 0;
        int waited = 0;
        @(negedge clk);
        pattern = 3'b101; copies = 4'd1; fill = 1'b0; start = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (done !== ((k % 64) == 63)) bad_done++;
            if (busy !== !((k % 64) == 0 || (k % 64) == 63)) bad_busy++;
            if (done === 1'b1) n_done++;
            if (k == 127) begin
                n_vec++; if ({word_out, count_out} !== {32'h0000_0005, 32'd1}) begin n_err++; $display("FAIL b2b op2: got %h/%0d want 00000005/1", word_out, count_out); end
            end
            if (k == 191) begin
                n_vec++; if ({word_out, count_out} !== {32'h0000_0000, 32'd30}) begin n_err++; $display("FAIL b2b op3: got %h/%0d want 00000000/30", word_out, count_out); end
            end
            if (k == 100) begin
                pattern = 3'b000; copies = 4'd0; fill = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        n_vec++; if (bad_done !== 0) begin n_err++; $display("FAIL b2b done_profile: got %0d bad cycles want 0", bad_done); end
        n_vec++; if (bad_busy !== 0) begin n_err++; $display("FAIL b2b busy_profile: got %0d bad cycles want 0", bad_busy); end
        n_vec++; if (n_done !== 3) begin n_err++; $display("FAIL b2b done_count: got %0d want 3", n_done); end
        while (done !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b drain_timeout: got done=%b want 1", done); end
        @(negedge clk);
        $display("back_to_back: %0d done pulses in 200 cycles, drained after %0d", n_done, waited);
    endtask

    initial begin
        test_reset();
        test_single_copy();
        test_full_copies();
        test_no_wrap();
        test_input_freeze();
        test_build_hold();
        test_fill_only();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
